// File: rtl/crc8_pkg.sv
// Shared definitions for the CRC-8 byte-stream sequencer and its serial engine.
//   state_e   : controller FSM states
//   CRC8_INIT : engine register value after reset
//   CRC8_POLY : x^8+x^5+x^4+x^3+1 with the x^8 term dropped
//   MODE_GEN / MODE_CHK : values of the per-frame mode input
package crc8_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        OUT,
        CMP,
        CRC,
        DONE
    } state_e;

    localparam logic [7:0] CRC8_INIT = 8'hFF;
    localparam logic [7:0] CRC8_POLY = 8'h39;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/crc8_stream_ctl_if.sv
// Byte-stream bundle around the CRC-8 sequencer.
//   mode              : frame mode (0 generate, 1 check)
//   s_data/s_valid/s_last/s_ready : upstream byte stream
//   m_data/m_valid/m_last/m_ready : downstream byte stream
//   chk_valid/chk_ok  : check-mode result
// slave  : view of the sequencer itself
// master : view of the surrounding source/sink
interface crc8_stream_ctl_if;

    logic       mode;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic       chk_valid;
    logic       chk_ok;

    modport slave (
        input  mode, s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_valid, m_last, chk_valid, chk_ok
    );

    modport master (
        output mode, s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_valid, m_last, chk_valid, chk_ok
    );

endinterface

// File: rtl/crc8_serial.sv
// Single-bit serial CRC-8 engine, one message bit per enabled clock, MSB first.
//   clk : clock
//   rst : synchronous active-high, loads CRC8_INIT
//   en  : shift one bit this cycle
//   din : message bit
//   crc : engine register, bit-reversed
module crc8_serial
    import crc8_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic       fb;

    always_comb begin
        fb     = lfsr_q[7] ^ din;
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= CRC8_INIT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            crc[i] = lfsr_q[7 - i];
        end
    end

endmodule

// File: rtl/crc8_stream_ctl.sv
// Byte-stream sequencer for crc8_serial. Each accepted byte is shifted into the
// engine MSB first (8 clocks), then forwarded downstream. Generate-mode frames
// get the CRC byte appended; in check mode the last byte is compared against the
// running CRC and the result reported on chk_valid/chk_ok.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : crc8_stream_ctl_if slave view (mode, s_* in, m_* out, chk_* out)
module crc8_stream_ctl
    import crc8_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    crc8_stream_ctl_if.slave   bus
);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] held_byte_q, held_byte_d;
    logic       held_last_q, held_last_d;
    logic       mode_q, mode_d;
    logic       active_q, active_d;
    logic       chk_ok_q, chk_ok_d;
    logic       chk_valid_q, chk_valid_d;

    logic       frame_mode;
    logic       s_ready;
    logic       m_valid;
    logic       m_last;
    logic [7:0] m_data;
    logic       eng_rst;
    logic       eng_en;
    logic [7:0] eng_crc;

    // Mode is only sampled on the first byte of a frame; later bytes use the latched copy.
    assign frame_mode = active_q ? mode_q : bus.mode;

    assign eng_rst = rst | (state_q == DONE);
    assign eng_en  = (state_q == SHIFT);

    crc8_serial u_engine (
        .clk (clk),
        .rst (eng_rst),
        .en  (eng_en),
        .din (held_byte_q[cnt_q]),
        .crc (eng_crc)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        held_byte_d = held_byte_q;
        held_last_d = held_last_q;
        mode_d      = mode_q;
        active_d    = active_q;
        chk_ok_d    = chk_ok_q;
        chk_valid_d = (state_q == CMP);
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        m_data      = 8'h00;

        case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                if (bus.s_valid) begin
                    held_byte_d = bus.s_data;
                    held_last_d = bus.s_last;
                    if (!active_q) begin
                        mode_d   = bus.mode;
                        active_d = 1'b1;
                    end
                    // The received CRC byte is compared, not shifted into the engine.
                    if (frame_mode == MODE_CHK && bus.s_last) begin
                        state_d = CMP;
                    end else begin
                        state_d = SHIFT;
                        cnt_d   = 3'd7;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q == 3'd0) begin
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            OUT: begin
                m_valid = 1'b1;
                m_data  = held_byte_q;
                m_last  = held_last_q && (mode_q == MODE_CHK);
                if (bus.m_ready) begin
                    if (!held_last_q) begin
                        state_d = IDLE;
                    end else if (mode_q == MODE_GEN) begin
                        state_d = CRC;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            CMP: begin
                chk_ok_d = (held_byte_q == eng_crc);
                state_d  = OUT;
            end
            CRC: begin
                m_valid = 1'b1;
                m_data  = eng_crc;
                m_last  = 1'b1;
                if (bus.m_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                active_d = 1'b0;
                cnt_d    = 3'd7;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd7;
            held_last_q <= 1'b0;
            mode_q      <= MODE_GEN;
            active_q    <= 1'b0;
            chk_ok_q    <= 1'b0;
            chk_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            held_last_q <= held_last_d;
            mode_q      <= mode_d;
            active_q    <= active_d;
            chk_ok_q    <= chk_ok_d;
            chk_valid_q <= chk_valid_d;
        end
    end

    // Payload byte is only observable in OUT/CMP, so it needs no reset.
    always_ff @(posedge clk) begin
        held_byte_q <= held_byte_d;
    end

    assign bus.s_ready   = s_ready;
    assign bus.m_valid   = m_valid;
    assign bus.m_last    = m_last;
    assign bus.m_data    = m_data;
    assign bus.chk_valid = chk_valid_q;
    assign bus.chk_ok    = chk_ok_q;

endmodule

// File: doc/crc8_stream_ctl.md
Name: crc8_stream_ctl

Overview:
- Byte-stream sequencer for the single-bit serial CRC-8 engine `crc8_serial`.
  - Polynomial x^8+x^5+x^4+x^3+1 (0x39 truncated).
  - Init 0xFF.
  - Engine's `crc` output is its register bit-reversed.
- Accepts framed bytes and serialises each one MSB-first into the engine, one bit per clk.
- Forwards every byte downstream.
- Generate mode: appends the CRC byte after the last payload byte.
- Check mode: treats the last byte as a received CRC and reports a match flag.
- Sits between a byte-wide frame source (UART/SPI framer) and a downstream sink.

Parameters:
- none; data width fixed at 8, CRC width fixed at 8.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mode  in  1  0 = generate, 1 = check; sampled on the first accepted byte of each frame
- s_data  in  8  input byte
- s_valid  in  1  input byte valid
- s_last  in  1  marks final byte of frame
- s_ready  out  1  input accept
- m_data  out  8  output byte
- m_valid  out  1  output valid
- m_last  out  1  final output byte of frame
- m_ready  in  1  output accept
- chk_valid  out  1  one-cycle pulse: check result available
- chk_ok  out  1  check result; held until next chk_valid

Behaviour:
- Reset values:
  - State IDLE.
  - s_ready=1, m_valid=0, m_last=0, chk_valid=0, chk_ok=0, m_data=0x00.
  - Bit counter 7.
  - Frame-active flag 0.
  - Engine reset asserted, so the engine register is 0xFF.
- Engine control:
  - Engine rst = rst | (state==DONE).
  - Engine en = (state==SHIFT).
  - Engine din = held_byte[cnt].
- States:
  - IDLE:
    - s_ready=1.
    - On s_valid: latch s_data into held_byte and s_last into held_last.
    - If the frame is not yet active: latch mode, set frame-active.
    - If check mode && s_last: go to CMP; else go to SHIFT with cnt=7.
  - SHIFT:
    - 8 cycles, cnt 7→0, one bit per cycle, MSB first; s_ready=0.
    - After cnt==0, go to OUT.
  - OUT:
    - m_valid=1, m_data=held_byte.
    - m_last = held_last && check mode. Generate mode never sets m_last on a payload byte.
    - On m_ready: if held_last go to CRC (generate) or DONE (check); else go to IDLE.
  - CMP:
    - One cycle.
    - chk_ok <= (held_byte == crc); chk_valid pulses in the next cycle.
    - Engine not clocked.
    - Go to OUT; the CRC byte itself is forwarded with m_last=1.
  - CRC (generate only):
    - m_valid=1, m_data=engine crc, m_last=1.
    - On m_ready go to DONE.
  - DONE:
    - One cycle; engine reset to 0xFF.
    - Clear frame-active, go to IDLE.
- Latency: byte accepted at cycle N; engine clocked N+1..N+8; m_valid first high at N+9. Per-byte throughput is at most 1 byte / 10 clk.
- m_valid, once asserted, holds with m_data/m_last stable until m_ready (AXI-style). s_ready depends only on state.
- Check-mode frame of one byte (CRC only, no payload): compare against 0xFF.
- Generate-mode frame of one byte: that byte is payload; CRC follows.
- mode changes mid-frame are ignored.
- Reset mid-operation: any state returns to IDLE next cycle, engine back to 0xFF, partially sent frame abandoned (no m_last), chk_valid not pulsed.
- Simultaneous rst and handshake: rst wins; the byte is not accepted.

Decomposition:
- Package crc8_pkg:
  - State enum {IDLE, SHIFT, OUT, CMP, CRC, DONE}.
  - CRC8_INIT = 8'hFF.
  - CRC8_POLY = 8'h39.
  - MODE_GEN = 0, MODE_CHK = 1.
- One sub-module: an instance of the existing crc8_serial. The controller contains no CRC arithmetic of its own.

Test Plan:
- Generate {0x00, last}:
  - outputs 0x00 (m_last=0), then 0xC6 (m_last=1);
  - m_valid first high 9 cycles after accept.
- Check {0x00}, {0xC6, last}:
  - outputs 0x00, 0xC6 (m_last=1);
  - chk_valid pulse with chk_ok=1.
- Check {0x00}, {0xC7, last}: chk_ok=0. Check single {0xFF, last}: chk_ok=1. Check single {0x5A, last}: chk_ok=0.
- Backpressure: m_ready=0 for 20 cycles in OUT and in CRC:
  - m_data/m_valid/m_last stable;
  - s_ready=0 throughout;
  - final output still 0xC6.
- Back-to-back generate frames {0x00, last} ×2: both append 0xC6, proving the DONE reset of the engine.
- rst asserted during SHIFT of the first byte:
  - next cycle all outputs at reset values;
  - a following generate {0x00, last} yields 0xC6.
